// File: rtl/audio_pwm_agc_if.sv
// rtl/audio_pwm_agc_if.sv - demod sample stream into the audio PWM/AGC stage
interface audio_pwm_agc_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] demod_in;
  logic              demod_tick;

  modport master (output demod_in, demod_tick);
  modport slave  (input  demod_in, demod_tick);
endinterface

// File: rtl/audio_pwm_agc.sv
// rtl/audio_pwm_agc.sv - DC removal, shift gain with AGC, 8-bit saturation and PWM audio output
// AUDIO_DC_BLOCK_EN selects the IIR DC estimator; otherwise the fixed midpoint is removed.
module audio_pwm_agc #(
  parameter int DATA_W        = 16,
  parameter int DC_SHIFT      = 10,
  parameter int DECAY_SAMPLES = 4096,
  parameter int PEAK_LOW      = 32
) (
  input  logic           clk,
  input  logic           RSTb,
  audio_pwm_agc_if.slave demod,
  input  logic [3:0]     gain_man,
  input  logic           agc_en,
  output logic           pwm_out,
  output logic [2:0]     gain_cur,
  output logic           clip,
  output logic           sample_tick
);
  localparam int Y_W   = DATA_W + 6;
  localparam int S_W   = Y_W - 8;
  localparam int WIN_W = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;

  typedef enum logic {TRACK, ATTACK} agc_state_t;

  logic                    v1, v2;
  logic [DATA_W-1:0]       x;
  logic signed [DATA_W:0]  ac, ac_nxt;
  logic signed [Y_W-1:0]   y;
  logic [S_W-1:0]          s;
  logic                    sat;
  logic [7:0]              out8, mag, pk_new;
  logic [7:0]              duty_buf, duty_act, cnt;
  logic [WIN_W-1:0]        win, win_nxt;
  logic [7:0]              peak, peak_nxt;
  logic [2:0]              gain_nxt, gain_man_c;
  agc_state_t              state, state_nxt;
  logic                    unused_bits;

`ifdef AUDIO_DC_BLOCK_EN
  localparam int ACC_W = DATA_W + DC_SHIFT;
  logic [ACC_W-1:0]  dc_acc;
  logic [DATA_W-1:0] dc;

  assign dc     = dc_acc[ACC_W-1:DC_SHIFT];
  assign ac_nxt = $signed({1'b0, x} - {1'b0, dc});

  // Settles at x<<DC_SHIFT, so it never exceeds ACC_W bits.
  always_ff @(posedge clk) begin
    if (!RSTb)   dc_acc <= '0;
    else if (v1) dc_acc <= dc_acc + ACC_W'(x) - ACC_W'(dc);
  end
`else
  localparam logic [DATA_W:0] MID = {2'b01, {(DATA_W-1){1'b0}}};
  assign ac_nxt = $signed({1'b0, x} - MID);
`endif

  assign y    = $signed({{5{ac[DATA_W]}}, ac}) <<< gain_cur;
  assign s    = y[Y_W-1:8];
  // In range only when every bit above bit 6 matches the sign.
  assign sat  = !((&s[S_W-1:7]) || !(|s[S_W-1:7]));
  assign out8 = sat ? (s[S_W-1] ? 8'h80 : 8'h7f) : s[7:0];
  assign mag  = out8[7] ? (~out8 + 8'd1) : out8;
  assign unused_bits = gain_man[3] ^ (^y[7:0]);

  always_ff @(posedge clk) begin
    if (!RSTb) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      x           <= '0;
      ac          <= '0;
      duty_buf    <= 8'd128;
      clip        <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      v1          <= demod.demod_tick;
      v2          <= v1;
      sample_tick <= v2;
      if (demod.demod_tick) x <= demod.demod_in;
      if (v1) ac <= ac_nxt;
      if (v2) begin
        duty_buf <= {~out8[7], out8[6:0]};
        clip     <= sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTb) begin
      cnt      <= 8'd0;
      duty_act <= 8'd128;
      pwm_out  <= 1'b0;
    end else begin
      cnt     <= cnt + 8'd1;
      pwm_out <= (cnt < duty_act);
      if (cnt == 8'd255) duty_act <= duty_buf;
    end
  end

  assign gain_man_c = (gain_man[2:0] > 3'd5) ? 3'd5 : gain_man[2:0];

  always_comb begin
    state_nxt = state;
    gain_nxt  = gain_cur;
    win_nxt   = win;
    peak_nxt  = peak;
    pk_new    = (mag > peak) ? mag : peak;
    if (!agc_en) begin
      state_nxt = TRACK;
      gain_nxt  = gain_man_c;
      win_nxt   = '0;
      peak_nxt  = 8'd0;
    end else begin
      case (state)
        TRACK: begin
          if (v2) begin
            if (sat) begin
              state_nxt = ATTACK;
            end else if (win == WIN_W'(DECAY_SAMPLES - 1)) begin
              if (({1'b0, pk_new} < 9'(PEAK_LOW)) && (gain_cur < 3'd5))
                gain_nxt = gain_cur + 3'd1;
              win_nxt  = '0;
              peak_nxt = 8'd0;
            end else begin
              win_nxt  = win + 1'b1;
              peak_nxt = pk_new;
            end
          end
        end
        ATTACK: begin
          if (gain_cur != 3'd0) gain_nxt = gain_cur - 3'd1;
          win_nxt   = '0;
          peak_nxt  = 8'd0;
          state_nxt = (v2 && sat) ? ATTACK : TRACK;
        end
        default: state_nxt = TRACK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTb) begin
      state    <= TRACK;
      gain_cur <= 3'd0;
      win      <= '0;
      peak     <= 8'd0;
    end else begin
      state    <= state_nxt;
      gain_cur <= gain_nxt;
      win      <= win_nxt;
      peak     <= peak_nxt;
    end
  end
endmodule

// File: tb/tb_audio_pwm_agc.sv
// tb/tb_audio_pwm_agc.sv - directed self-checking bench for audio_pwm_agc
// Bench uses DC_SHIFT=4 and DECAY_SAMPLES=16 to keep runs short.
module tb_audio_pwm_agc;
  logic       clk = 1'b0;
  logic       RSTb;
  logic [3:0] gain_man;
  logic       agc_en;
  logic       pwm_out;
  logic [2:0] gain_cur;
  logic       clip;
  logic       sample_tick;
  int         tests = 0;
  int         fails = 0;

  audio_pwm_agc_if #(.DATA_W(16)) bus ();

  audio_pwm_agc #(
    .DATA_W(16), .DC_SHIFT(4), .DECAY_SAMPLES(16), .PEAK_LOW(32)
  ) dut (
    .clk(clk), .RSTb(RSTb), .demod(bus), .gain_man(gain_man), .agc_en(agc_en),
    .pwm_out(pwm_out), .gain_cur(gain_cur), .clip(clip), .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Captures the S3 outputs of one sample, then lets the AGC settle.
  task automatic send(input logic [15:0] v, output logic st, output logic cl, output int db);
    bus.demod_in   = v;
    bus.demod_tick = 1'b1;
    step();
    bus.demod_tick = 1'b0;
    step();
    step();
    st = sample_tick;
    cl = clip;
    db = int'(dut.duty_buf);
    step();
    step();
  endtask

  task automatic count_high(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      step();
      h += int'(pwm_out);
    end
  endtask

  initial begin
    logic       st, cl;
    int         db, h, g, any_st;
    logic [3:0] gm_in [5]  = '{4'd7, 4'd3, 4'd6, 4'd10, 4'd0};
    int         gm_exp [5] = '{5, 3, 5, 2, 0};

    RSTb = 1'b0; agc_en = 1'b0; gain_man = 4'd0;
    bus.demod_in = '0; bus.demod_tick = 1'b0;
    step(); step();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_gain", gain_cur, 0);
    chk("rst_clip", clip, 0);
    chk("rst_tick", sample_tick, 0);
    RSTb = 1'b1;
    count_high(256, h);
    chk("rst_duty128", h, 128);

    for (int i = 0; i < 5; i++) begin
      gain_man = gm_in[i];
      step();
      chk("man_gain", gain_cur, gm_exp[i]);
    end

    // Reset mid-stream: clip is high and a sample sits in S2 when reset hits.
    gain_man = 4'd2;
    step();
    send(16'hFFFF, st, cl, db);
    chk("pre_clip", cl, 1);
    bus.demod_in = 16'h9000; bus.demod_tick = 1'b1;
    step();
    bus.demod_tick = 1'b0;
    step();
    RSTb = 1'b0;
    gain_man = 4'd0;
    step();
    chk("mid_rst_pwm", pwm_out, 0);
    chk("mid_rst_gain", gain_cur, 0);
    chk("mid_rst_clip", clip, 0);
    RSTb = 1'b1;
    any_st = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      any_st += int'(sample_tick);
    end
    chk("mid_rst_discard", any_st, 0);
    count_high(256, h);
    chk("mid_rst_duty128", h, 128);

`ifdef AUDIO_DC_BLOCK_EN
    send(16'h4000, st, cl, db);
    chk("dc_first", db, 192);
    for (int i = 1; i < 128; i++) begin
      send(16'h4000, st, cl, db);
      for (int k = 0; k < 59; k++) step();
    end
    chk("dc_converged", (db >= 127 && db <= 129), 1);
`else
    // Latency and period-aligned duty update, tick launched at counter 99.
    for (int i = 0; i < 300 && dut.cnt !== 8'd99; i++) step();
    chk("cnt_align", dut.cnt, 99);
    bus.demod_in = 16'h9000; bus.demod_tick = 1'b1;
    step();
    bus.demod_tick = 1'b0;
    chk("lat_t1", sample_tick, 0);
    h = 0;
    step();
    h += int'(pwm_out);
    chk("lat_t2", sample_tick, 0);
    step();
    h += int'(pwm_out);
    chk("lat_t3", sample_tick, 1);
    chk("lat_duty_buf", dut.duty_buf, 144);
    chk("lat_clip", clip, 0);
    for (int i = 0; i < 300 && dut.cnt !== 8'd255; i++) begin
      step();
      h += int'(pwm_out);
    end
    chk("old_period", h, 28);
    count_high(256, h);
    chk("new_period", h, 144);

    // AGC attack.
    gain_man = 4'd4;
    step();
    chk("atk_start", gain_cur, 4);
    agc_en = 1'b1;
    g = 4;
    for (int i = 0; i < 6; i++) begin
      send((i % 2 == 1) ? 16'hFFFF : 16'h0000, st, cl, db);
      chk("atk_tick", st, 1);
      chk("atk_clip", cl, (g > 0) ? 1 : 0);
      if (g == 0) chk("atk_duty", db, (i % 2 == 1) ? 255 : 0);
      if (g > 0) g--;
      chk("atk_gain", gain_cur, g);
    end

    // AGC decay with one clip on a window-end sample.
    agc_en = 1'b0;
    gain_man = 4'd0;
    step();
    agc_en = 1'b1;
    g = 0;
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 16; k++) begin
        send((w == 3 && k == 15) ? 16'hFFFF : 16'h8010, st, cl, db);
        if (k == 14) chk("dec_hold", gain_cur, g);
        if (k == 15) begin
          if (w == 3) begin
            chk("dec_clip", cl, 1);
            g--;
          end else if (g < 5) begin
            g++;
          end
          chk("dec_step", gain_cur, g);
        end
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/audio_pwm_agc.md
Name: audio_pwm_agc

Overview:
- Audio output stage directly downstream of the AM demodulator; consumes the 16-bit demod sample and its tick.
- Removes DC from the sample, applies a shift gain (manual or automatic), saturates to 8 bits and drives a glitch-free 8-bit PWM audio output.
- Replaces the fixed count-compare PWM and shift-select logic in the board top level.

Parameters:
- DATA_W, 16, demod sample width (unsigned)
- DC_SHIFT, 10, DC-estimator IIR coefficient exponent (alpha = 2^-DC_SHIFT)
- DECAY_SAMPLES, 4096, AGC gain-increase window length, in samples
- PEAK_LOW, 32, window peak |out8| below which AGC raises gain

Ports:
- clk  in  1  system clock (50.25 MHz)
- RSTb  in  1  reset, synchronous, active-low
- demod_in  in  DATA_W  AM demod magnitude sample
- demod_tick  in  1  one-cycle strobe: demod_in valid
- gain_man  in  4  manual gain from SPI; bits [2:0] used, values 6 and 7 clamp to 5
- agc_en  in  1  1 = automatic gain, 0 = manual gain
- pwm_out  out  1  registered PWM audio output
- gain_cur  out  3  gain currently applied (0..5)
- clip  out  1  high for the sample that saturated; held until the next sample
- sample_tick  out  1  one-cycle strobe when a new duty value is buffered

Behaviour:
- Reset: one clk with RSTb low, honoured at any time including mid-pipeline and mid-window.
  - pwm_out=0, gain_cur=0, clip=0, sample_tick=0.
  - PWM counter=0; duty_buf=duty_act=128; dc_acc=0; AGC window counter=0; peak=0.
  - Any in-flight sample is discarded.
- Pipeline, fixed latency:
  - S1 (tick+1): latch x=demod_in.
  - S2 (tick+2):
    - dc = dc_acc>>DC_SHIFT.
    - ac = x - dc, signed DATA_W+1.
    - dc_acc <= dc_acc + x - dc; accumulator width DATA_W+DC_SHIFT, unsigned, never wraps.
  - S3 (tick+3):
    - y = ac <<< gain_cur; s = y >>> 8.
    - out8 = s saturated to [-128,127]; clip = (s out of range).
    - duty_buf = out8 + 128; sample_tick pulses this cycle.
- A tick arriving while the pipeline is busy is accepted; ticks closer than 3 clks are legal, since each stage is a plain register.
- PWM:
  - 8-bit counter increments every clk and wraps 255->0.
  - duty_act <= duty_buf only on the cycle the counter is 255, so there is no mid-period change.
  - pwm_out <= (counter < duty_act). Duty 0 gives constant 0; duty 255 gives high 255 of 256 clks.
- Gain, agc_en=0: gain_cur = min(gain_man[2:0],5), updated every clk. AGC window counter and peak are held at 0.
- AGC, agc_en=1, evaluated at S3 of each sample. States: TRACK and ATTACK.
  - TRACK: peak = max(peak,|out8|) and window counter += 1.
    - If clip: go to ATTACK.
    - Else, when the counter reaches DECAY_SAMPLES-1: if peak < PEAK_LOW and gain_cur < 5, gain_cur += 1. Counter and peak then clear.
  - ATTACK:
    - gain_cur -= 1 if > 0. Counter and peak clear. Return to TRACK.
    - If the next sample also clips, stay in ATTACK and decrement again.
  - Clip on the window-end sample: the decrement wins and there is no increment.
  - agc_en 0->1: AGC starts from the current manual gain with a cleared window.
  - agc_en 1->0: manual gain takes effect next clk.
- Arithmetic is two's complement throughout. The |out8| of -128 is 128.

Optional Feature:
- Macro: AUDIO_DC_BLOCK_EN.
- Defined: the IIR DC removal above.
- Undefined:
  - ac = x - 2^(DATA_W-1), a fixed midpoint.
  - dc_acc and its logic are absent.
  - Latency is unchanged; S2 is still a register stage.

Test Plan:
- Reset mid-stream: RSTb low 1 clk during an active tone.
  - Next clk: pwm_out=0, gain_cur=0, clip=0.
  - Afterwards pwm_out is high 128 of every 256 clks until the first new sample.
- Manual gain: agc_en=0, gain_man=7 -> gain_cur=5. Then gain_man=3 -> gain_cur=3 on the next clk.
- Latency/buffering: single tick with feature undefined, gain 0, demod_in=0x9000.
  - sample_tick 3 clks after the tick; duty_buf=144.
  - pwm_out duty changes only after the next counter=255.
- DC block: AUDIO_DC_BLOCK_EN defined, demod_in=0x4000 constant, tick every 64 clks.
  - duty_buf converges to 128+/-1 within 8*2^DC_SHIFT samples.
- AGC attack: agc_en=1 from gain_man=4, input alternating 0x0000/0xFFFF.
  - clip=1 and gain_cur drops by 1 per clipped sample, stopping at 0.
- AGC decay: agc_en=1, gain 0, DECAY_SAMPLES=16 (overridden), small signal |out8|<8.
  - gain_cur +1 every 16 samples until 5, then holds.
  - Forcing one clip on the 16th sample -> decrement, no increment.
